// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_pkg                                                    |
// | Brief    : Shared types and helpers for the parametrised register file.  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_clr_fsm                                                |
// | Brief    : Sequenced clear engine, one register zeroed per cycle.         |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr_req,
    output logic          o_clr_busy,
    output logic          o_clr_done,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_adr
);

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    clr_state_t    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_clr_req) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    // cnt holds at the last address rather than wrapping
                    if (r_cnt == c_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_busy = r_busy;
    assign o_clr_done = r_done;
    assign o_clr_we   = r_busy;
    assign o_clr_adr  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_param                                                  |
// | Brief    : 1W/2R register file with bypass, scoreboard and clear engine.  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int READ_REG = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    output logic             w_rdy,
    input  logic [AW-1:0]    W_Adr,
    input  logic [WIDTH-1:0] W,
    input  logic [AW-1:0]    R_Adr,
    input  logic [AW-1:0]    S_Adr,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] S,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_adr,
    output logic             R_pend,
    output logic             S_pend,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_nxt;
    logic             w_clr_busy;
    logic             w_clr_done;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_adr;
    logic             w_wr_eff;
    logic             w_rsv_eff;

    regfile_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk        (clk),
        .reset      (reset),
        .i_clr_req  (clr_req),
        .o_clr_busy (w_clr_busy),
        .o_clr_done (w_clr_done),
        .o_clr_we   (w_clr_we),
        .o_clr_adr  (w_clr_adr)
    );

    assign w_rdy    = ~w_clr_busy;
    assign clr_busy = w_clr_busy;
    assign clr_done = w_clr_done;

    // Accepted writes to a hardwired-zero register are treated as no-ops everywhere
    assign w_wr_eff  = we && !w_clr_busy && !((ZERO_REG != 0) && (W_Adr == '0));
    assign w_rsv_eff = rsv_en && !((ZERO_REG != 0) && (rsv_adr == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_clr_we) begin
            r_mem[w_clr_adr] <= '0;
        end else if (w_wr_eff) begin
            r_mem[W_Adr] <= W;
        end
    end

    if (READ_REG != 0) begin : g_rd_reg
        logic [WIDTH-1:0] r_r;
        logic [WIDTH-1:0] r_s;
        logic [WIDTH-1:0] w_r_nxt;
        logic [WIDTH-1:0] w_s_nxt;

        // Write-first: whatever lands in the addressed register this edge is returned
        always_comb begin
            w_r_nxt = r_mem[R_Adr];
            w_s_nxt = r_mem[S_Adr];
            if (w_clr_we && (w_clr_adr == R_Adr)) w_r_nxt = '0;
            if (w_clr_we && (w_clr_adr == S_Adr)) w_s_nxt = '0;
            if (w_wr_eff && (W_Adr == R_Adr)) w_r_nxt = W;
            if (w_wr_eff && (W_Adr == S_Adr)) w_s_nxt = W;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_r <= '0;
                r_s <= '0;
            end else begin
                r_r <= w_r_nxt;
                r_s <= w_s_nxt;
            end
        end

        assign R = r_r;
        assign S = r_s;
    end else begin : g_rd_comb
        always_comb begin
            R = r_mem[R_Adr];
            S = r_mem[S_Adr];
            if ((BYPASS != 0) && w_wr_eff && (W_Adr == R_Adr)) R = W;
            if ((BYPASS != 0) && w_wr_eff && (W_Adr == S_Adr)) S = W;
        end
    end

    // Reservation applied after write-clear so a same-edge new producer stays pending
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_eff) w_pend_nxt[W_Adr] = 1'b0;
        if (w_rsv_eff) w_pend_nxt[rsv_adr] = 1'b1;
        if (w_clr_done) w_pend_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_pend <= '0;
        else        r_pend <= w_pend_nxt;
    end

    assign R_pend = r_pend[R_Adr];
    assign S_pend = r_pend[S_Adr];

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_param                                               |
// | Brief    : Directed vector bench for three regfile_param configurations.  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  W_Adr;
    logic [15:0] W;
    logic [2:0]  R_Adr;
    logic [2:0]  S_Adr;
    logic        rsv_en;
    logic [2:0]  rsv_adr;
    logic        clr_req;

    logic [15:0] r0, s0, r1, s1, r2, s2;
    logic        wr0, wr1, wr2, rp0, rp1, rp2, sp0, sp1, sp2;
    logic        cb0, cb1, cb2, cd0, cd1, cd2;

    int checks;
    int errors;

    // u0: combinational + bypass, u1: registered reads, u2: hardwired zero register
    regfile_param #(.WIDTH(16), .DEPTH(8), .READ_REG(0), .BYPASS(1), .ZERO_REG(0)) u0 (
        .clk(clk), .reset(reset), .we(we), .w_rdy(wr0), .W_Adr(W_Adr), .W(W),
        .R_Adr(R_Adr), .S_Adr(S_Adr), .R(r0), .S(s0), .rsv_en(rsv_en), .rsv_adr(rsv_adr),
        .R_pend(rp0), .S_pend(sp0), .clr_req(clr_req), .clr_busy(cb0), .clr_done(cd0));
    regfile_param #(.WIDTH(16), .DEPTH(8), .READ_REG(1), .BYPASS(1), .ZERO_REG(0)) u1 (
        .clk(clk), .reset(reset), .we(we), .w_rdy(wr1), .W_Adr(W_Adr), .W(W),
        .R_Adr(R_Adr), .S_Adr(S_Adr), .R(r1), .S(s1), .rsv_en(rsv_en), .rsv_adr(rsv_adr),
        .R_pend(rp1), .S_pend(sp1), .clr_req(clr_req), .clr_busy(cb1), .clr_done(cd1));
    regfile_param #(.WIDTH(16), .DEPTH(8), .READ_REG(0), .BYPASS(1), .ZERO_REG(1)) u2 (
        .clk(clk), .reset(reset), .we(we), .w_rdy(wr2), .W_Adr(W_Adr), .W(W),
        .R_Adr(R_Adr), .S_Adr(S_Adr), .R(r2), .S(s2), .rsv_en(rsv_en), .rsv_adr(rsv_adr),
        .R_pend(rp2), .S_pend(sp2), .clr_req(clr_req), .clr_busy(cb2), .clr_done(cd2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  wadr;
        logic [15:0] wdata;
        logic [2:0]  radr;
        logic [2:0]  sadr;
        logic        rsv;
        logic [2:0]  rsvadr;
        logic [15:0] er0;
        logic [15:0] es0;
        logic        erp;
        logic        esp;
        logic [15:0] er2;
        logic        erp2;
        logic [15:0] er1;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mkv(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                                 input logic [2:0] ra, input logic [2:0] sa, input logic rv,
                                 input logic [2:0] rva, input logic [15:0] e_r0,
                                 input logic [15:0] e_s0, input logic e_rp, input logic e_sp,
                                 input logic [15:0] e_r2, input logic e_rp2,
                                 input logic [15:0] e_r1);
        vec_t v;
        v.we = w; v.wadr = wa; v.wdata = wd; v.radr = ra; v.sadr = sa;
        v.rsv = rv; v.rsvadr = rva; v.er0 = e_r0; v.es0 = e_s0; v.erp = e_rp;
        v.esp = e_sp; v.er2 = e_r2; v.erp2 = e_rp2; v.er1 = e_r1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; W_Adr = '0; W = '0; rsv_en = 1'b0; rsv_adr = '0; clr_req = 1'b0;
    endtask

    task automatic check_idle_state(input string tag);
        chk({tag, "_r0"}, r0, 16'h0);
        chk({tag, "_s0"}, s0, 16'h0);
        chk({tag, "_r1"}, r1, 16'h0);
        chk({tag, "_s1"}, s1, 16'h0);
        chk({tag, "_r2"}, r2, 16'h0);
        chk({tag, "_pend"}, {15'd0, rp0 | sp0 | rp1 | sp1 | rp2 | sp2}, 16'h0);
        chk({tag, "_w_rdy"}, {15'd0, wr0 & wr1 & wr2}, 16'h1);
        chk({tag, "_busy"}, {15'd0, cb0 | cb1 | cb2}, 16'h0);
        chk({tag, "_done"}, {15'd0, cd0 | cd1 | cd2}, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int busy_cnt, done_cnt, done_at;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        R_Adr  = '0;
        S_Adr  = '0;
        idle_inputs();

        //                  we wa    wdata     ra sa rv rva er0       es0       erp  esp  er2       erp2 er1
        vecs[0] = mkv(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 1'b0, 3'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'h0000);
        vecs[1] = mkv(1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF);
        vecs[2] = mkv(1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b1, 3'd2, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hBEEF);
        vecs[3] = mkv(1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000);
        vecs[4] = mkv(1'b1, 3'd2, 16'h1357, 3'd2, 3'd4, 1'b0, 3'd0, 16'h1357, 16'h0000, 1'b1, 1'b0, 16'h1357, 1'b1, 16'h0000);
        vecs[5] = mkv(1'b1, 3'd4, 16'h00AA, 3'd4, 3'd2, 1'b1, 3'd4, 16'h00AA, 16'h1357, 1'b0, 1'b0, 16'h00AA, 1'b0, 16'h1357);
        vecs[6] = mkv(1'b0, 3'd0, 16'h0000, 3'd4, 3'd2, 1'b0, 3'd0, 16'h00AA, 16'h1357, 1'b1, 1'b0, 16'h00AA, 1'b1, 16'h00AA);
        vecs[7] = mkv(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd1, 1'b0, 3'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00AA);
        vecs[8] = mkv(1'b0, 3'd0, 16'h0000, 3'd0, 3'd4, 1'b1, 3'd0, 16'hFFFF, 16'h00AA, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hFFFF);
        vecs[9] = mkv(1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b0, 3'd0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hFFFF);

        repeat (3) @(posedge clk);
        #1;
        check_idle_state("in_reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle_state("post_reset");

        for (int i = 0; i < 10; i++) begin
            we = vecs[i].we; W_Adr = vecs[i].wadr; W = vecs[i].wdata;
            R_Adr = vecs[i].radr; S_Adr = vecs[i].sadr;
            rsv_en = vecs[i].rsv; rsv_adr = vecs[i].rsvadr;
            @(negedge clk);
            chk($sformatf("v%0d_R", i), r0, vecs[i].er0);
            chk($sformatf("v%0d_S", i), s0, vecs[i].es0);
            chk($sformatf("v%0d_Rpend", i), {15'd0, rp0}, {15'd0, vecs[i].erp});
            chk($sformatf("v%0d_Spend", i), {15'd0, sp0}, {15'd0, vecs[i].esp});
            chk($sformatf("v%0d_R_zero", i), r2, vecs[i].er2);
            chk($sformatf("v%0d_Rpend_zero", i), {15'd0, rp2}, {15'd0, vecs[i].erp2});
            chk($sformatf("v%0d_R_regd", i), r1, vecs[i].er1);
            @(posedge clk); #1;
        end
        idle_inputs();

        // Registered read port returns a same-edge write one cycle later
        we = 1'b1; W_Adr = 3'd5; W = 16'h1234; R_Adr = 3'd5; S_Adr = 3'd5;
        @(posedge clk); #1;
        we = 1'b0;
        chk("regd_R_write_first", r1, 16'h1234);
        chk("regd_S_write_first", s1, 16'h1234);
        chk("comb_R_storage", r0, 16'h1234);

        // Fill every register, reserve r6, then run a full clear sweep
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; W_Adr = 3'(i); W = 16'h1000 + 16'(i);
            @(posedge clk); #1;
        end
        we = 1'b0;
        rsv_en = 1'b1; rsv_adr = 3'd6;
        @(posedge clk); #1;
        rsv_en = 1'b0; R_Adr = 3'd6; S_Adr = 3'd7;
        @(negedge clk);
        chk("fill_r6_pend", {15'd0, rp0}, 16'h1);
        chk("fill_r7", s0, 16'h1007);

        @(posedge clk); #1;
        clr_req = 1'b1; R_Adr = 3'd1; S_Adr = 3'd2;
        @(posedge clk); #1;
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) begin rsv_en = 1'b1; rsv_adr = 3'd1; end
            if (k == 7) begin we = 1'b1; W_Adr = 3'd0; W = 16'hDEAD; end
            if (k == 8) begin rsv_en = 1'b1; rsv_adr = 3'd2; end
            @(negedge clk);
            busy_cnt += int'(cb0);
            done_cnt += int'(cd0);
            if (cd0 && done_at < 0) done_at = k;
            if (k == 1) chk("sweep_partial_r1_kept", r0, 16'h1001);
            if (k == 2) chk("sweep_partial_r1_clr", r0, 16'h0000);
            if (k == 5) chk("sweep_rsv_honoured", {15'd0, rp0}, 16'h1);
            if (k == 7) chk("sweep_w_rdy_low", {15'd0, wr0}, 16'h0);
            if (k == 8) chk("done_w_rdy_high", {15'd0, wr0}, 16'h1);
            if (k == 9) chk("done_pend_cleared", {15'd0, rp0}, 16'h0);
            if (k == 9) chk("done_rsv_ignored", {15'd0, sp0}, 16'h0);
            @(posedge clk); #1;
            idle_inputs();
        end
        chk("sweep_busy_cycles", 16'(busy_cnt), 16'd8);
        chk("sweep_done_pulses", 16'(done_cnt), 16'd1);
        chk("sweep_done_cycle", 16'(done_at), 16'd8);

        for (int i = 0; i < 8; i++) begin
            R_Adr = 3'(i); S_Adr = 3'(7 - i);
            @(negedge clk);
            chk($sformatf("cleared_R%0d", i), r0, 16'h0);
            chk($sformatf("cleared_pend%0d", i), {15'd0, rp0 | sp0}, 16'h0);
            @(posedge clk); #1;
        end

        // Reset asserted during sweep cycle 3 aborts the sweep with no done pulse
        we = 1'b1; W_Adr = 3'd3; W = 16'h3333;
        @(posedge clk); #1;
        we = 1'b0; R_Adr = 3'd3; clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midsweep_busy_before", {15'd0, cb0}, 16'h1);
        chk("midsweep_r3_before", r0, 16'h3333);
        reset = 1'b0;
        #1;
        chk("midsweep_busy_async", {15'd0, cb0}, 16'h0);
        chk("midsweep_r3_zeroed", r0, 16'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            busy_cnt += int'(cb0);
            done_cnt += int'(cd0);
        end
        chk("abort_no_busy", 16'(busy_cnt), 16'd0);
        chk("abort_no_done", 16'(done_cnt), 16'd0);
        chk("abort_w_rdy", {15'd0, wr0}, 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
